// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Rebuilds the word, checks parity with an XOR accumulator, flags framing errors.
module serial_parity_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              acc;
    logic              perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            acc        <= 1'b0;
            perr       <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // valid is a strobe: it drops on the next edge whether or not bit_en is high
            valid <= 1'b0;
            if (bit_en) begin
                unique case (state)
                    IDLE: begin
                        if (!rx) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            acc     <= PARITY_ODD;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {rx, shreg[DATA_W-1:1]};
                        acc     <= acc ^ rx;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        perr  <= acc ^ rx;
                        state <= STOP;
                    end
                    STOP: begin
                        data_out   <= shreg;
                        parity_err <= perr;
                        frame_err  <= ~rx;
                        valid      <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Scoreboard bench for serial_parity_rx: an even-parity and an odd-parity instance
// share clock, reset and bit_en; each has its own serial line and expected-result queue.
module tb_serial_parity_rx;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       rx_e = 1'b1;
    logic       rx_o = 1'b1;
    logic [7:0] data_e, data_o;
    logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    exp_t q_e[$];
    exp_t q_o[$];
    int   vt_e[$];
    logic prev_v_e = 1'b0;
    logic prev_v_o = 1'b0;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_e (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx_e),
        .data_out(data_e), .valid(valid_e), .parity_err(perr_e),
        .frame_err(ferr_e), .busy(busy_e)
    );

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_o (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx_o),
        .data_out(data_o), .valid(valid_o), .parity_err(perr_o),
        .frame_err(ferr_o), .busy(busy_o)
    );

    function automatic void chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endfunction

    // monitor: pops an expected record whenever a DUT raises valid
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (valid_e) begin
                vt_e.push_back(cyc);
                if (q_e.size() == 0) chk("unexpected_valid_e", 1, 0);
                else begin
                    e = q_e.pop_front();
                    chk("data_e", int'(data_e), int'(e.data));
                    chk("perr_e", int'(perr_e), int'(e.perr));
                    chk("ferr_e", int'(ferr_e), int'(e.ferr));
                end
                chk("double_valid_e", int'(prev_v_e), 0);
            end
            if (valid_o) begin
                if (q_o.size() == 0) chk("unexpected_valid_o", 1, 0);
                else begin
                    e = q_o.pop_front();
                    chk("data_o", int'(data_o), int'(e.data));
                    chk("perr_o", int'(perr_o), int'(e.perr));
                    chk("ferr_o", int'(ferr_o), int'(e.ferr));
                end
                chk("double_valid_o", int'(prev_v_o), 0);
            end
        end
        prev_v_e = valid_e;
        prev_v_o = valid_o;
    end

    // one bit time: rx held for one bit_en cycle, then gap idle cycles
    task automatic strobe(input bit odd, input logic b, input int gap);
        if (odd) rx_o = b; else rx_e = b;
        bit_en = 1'b1;
        @(negedge clk);
        if (gap > 0) begin
            bit_en = 1'b0;
            if (odd) rx_o = ~b; else rx_e = ~b;  // glitch between strobes must be ignored
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send(input bit odd, input logic [7:0] d, input logic par, input logic stp,
                        input int gap, input int stall_at, input logic eperr, input logic eferr);
        exp_t e;
        e.data = d; e.perr = eperr; e.ferr = eferr;
        if (odd) q_o.push_back(e); else q_e.push_back(e);
        strobe(odd, 1'b0, gap);
        chk(odd ? "busy_o_after_start" : "busy_e_after_start", int'(odd ? busy_o : busy_e), 1);
        for (int i = 0; i < 8; i++) begin
            strobe(odd, d[i], gap);
            if (i == stall_at) begin
                bit_en = 1'b0;
                repeat (5) @(negedge clk);
            end
        end
        strobe(odd, par, gap);
        strobe(odd, stp, 0);
        bit_en = 1'b0;
        if (odd) rx_o = 1'b1; else rx_e = 1'b1;
        chk(odd ? "busy_o_after_stop" : "busy_e_after_stop", int'(odd ? busy_o : busy_e), 0);
    endtask

    initial begin
        int t0;
        @(negedge clk);
        chk("rst_data", int'(data_e), 0);
        chk("rst_valid", int'(valid_e), 0);
        chk("rst_perr", int'(perr_e), 0);
        chk("rst_ferr", int'(ferr_e), 0);
        chk("rst_busy", int'(busy_e), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // good frame and parity error, bit_en every 4th cycle
        send(1'b0, 8'hA5, 1'b0, 1'b1, 3, -1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        send(1'b0, 8'hA5, 1'b1, 1'b1, 3, -1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);

        // odd parity instance
        send(1'b1, 8'h07, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        send(1'b1, 8'h07, 1'b1, 1'b1, 1, -1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        // framing error then recovery
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1, -1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        send(1'b0, 8'h01, 1'b1, 1'b1, 1, -1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // back-to-back with bit_en tied high
        t0 = vt_e.size();
        send(1'b0, 8'h12, 1'b0, 1'b1, 0, -1, 1'b0, 1'b0);
        send(1'b0, 8'hFE, 1'b1, 1'b1, 0, -1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        if (vt_e.size() >= t0 + 2) chk("b2b_spacing", vt_e[t0+1] - vt_e[t0], 11);
        else chk("b2b_valid_count", vt_e.size() - t0, 2);

        // same with a 5-cycle stall mid-DATA
        send(1'b0, 8'h12, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
        send(1'b0, 8'hFE, 1'b1, 1'b1, 0, 3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // reset mid-frame after 4 data bits (0x5A low nibble, then abort)
        strobe(1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(1'b0, i[0], 0);
        bit_en = 1'b0;
        rx_e = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_data", int'(data_e), 0);
        chk("abort_valid", int'(valid_e), 0);
        chk("abort_perr", int'(perr_e), 0);
        chk("abort_busy", int'(busy_e), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(1'b0, 8'h5A, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0);

        for (int i = 0; i < 20 && (q_e.size() != 0 || q_o.size() != 0); i++) @(negedge clk);
        chk("pending_e", q_e.size(), 0);
        chk("pending_o", q_o.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
